// File: rtl/cv32e40p_apu_str_pkg.sv
// Shared types and constants for the APU string/byte-op unit.
// Opcodes, FSM states, upstream flag bit positions.
package cv32e40p_apu_str_pkg;

  localparam int STR_OP_STRLEN  = 0;
  localparam int STR_OP_CMPMASK = 1;
  localparam int STR_OP_COUNT   = 2;
  localparam int STR_OP_REV     = 3;
  localparam int STR_OP_UPPER   = 4;
  localparam int STR_OP_SCAN    = 5;

  localparam int STR_FLAG_ILLEGAL = 0;
  localparam int STR_FLAG_ZERO    = 1;

  typedef enum logic [1:0] {
    STR_IDLE,
    STR_SCAN,
    STR_DONE
  } str_state_e;

  function automatic logic has_zero_byte(input logic [31:0] w);
    return (w[7:0] == 8'h00) | (w[15:8] == 8'h00) |
           (w[23:16] == 8'h00) | (w[31:24] == 8'h00);
  endfunction

endpackage

// File: rtl/cv32e40p_apu_str_unit_if.sv
// APU request/grant/rvalid bundle between the core and the unit.
// master = core side, slave = accelerator side.
interface cv32e40p_apu_str_unit_if #(
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5
) ();

  logic                     req;
  logic                     gnt;
  logic [NARGS-1:0][31:0]   operands;
  logic [WOP-1:0]           op;
  logic [NDSFLAGS-1:0]      flags_ds;
  logic                     rvalid;
  logic [31:0]              result;
  logic [NUSFLAGS-1:0]      flags_us;

  modport master (
    output req, operands, op, flags_ds,
    input  gnt, rvalid, result, flags_us
  );

  modport slave (
    input  req, operands, op, flags_ds,
    output gnt, rvalid, result, flags_us
  );

endinterface

// File: rtl/cv32e40p_apu_str_alu.sv
// Combinational single-pass byte-op evaluator.
// Feeds stage 0 of the result pipeline.
module cv32e40p_apu_str_alu
  import cv32e40p_apu_str_pkg::*;
#(
  parameter int WOP      = 6,
  parameter int NUSFLAGS = 5
) (
  input  logic [WOP-1:0]      op_i,
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  input  logic [7:0]          key_i,
  output logic [31:0]         result_o,
  output logic [NUSFLAGS-1:0] flags_o
);

  logic is_strlen, is_cmp, is_count;
  logic is_rev, is_upper, is_scan;

  assign is_strlen = (op_i == WOP'(STR_OP_STRLEN));
  assign is_cmp    = (op_i == WOP'(STR_OP_CMPMASK));
  assign is_count  = (op_i == WOP'(STR_OP_COUNT));
  assign is_rev    = (op_i == WOP'(STR_OP_REV));
  assign is_upper  = (op_i == WOP'(STR_OP_UPPER));
  assign is_scan   = (op_i == WOP'(STR_OP_SCAN));

  logic [2:0]  len;
  logic [2:0]  cnt;
  logic [3:0]  mask;
  logic [31:0] rev;
  logic [31:0] upper;

  // per-byte candidate results for every op
  always_comb begin
    logic [7:0] x;
    x     = '0;
    len   = 3'd4;
    cnt   = '0;
    mask  = '0;
    rev   = '0;
    upper = '0;
    for (int i = 3; i >= 0; i--) begin
      if (a_i[8*i +: 8] == 8'h00) len = 3'(i);
    end
    for (int i = 0; i < 4; i++) begin
      x = a_i[8*i +: 8];
      mask[i] = (x == b_i[8*i +: 8]);
      cnt = cnt + 3'(x == key_i);
      rev[8*(3-i) +: 8] = x;
      if (x >= 8'h61 && x <= 8'h7a) x = x - 8'h20;
      upper[8*i +: 8] = x;
    end
  end

  // opcode select and flag generation
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    flags_o[STR_FLAG_ZERO] = has_zero_byte(a_i);
    unique case (1'b1)
      is_strlen: result_o = {29'd0, len};
      is_cmp:    result_o = {28'd0, mask};
      is_count:  result_o = {29'd0, cnt};
      is_rev:    result_o = rev;
      is_upper:  result_o = upper;
      is_scan:   result_o = '0;
      default:   flags_o[STR_FLAG_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/cv32e40p_apu_str_unit.sv
// APU responder for string/byte ops: fixed-latency pipe
// plus a multicycle byte-scan FSM, results in grant order.
module cv32e40p_apu_str_unit
  import cv32e40p_apu_str_pkg::*;
#(
  parameter int LATENCY          = 2,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cv32e40p_apu_str_unit_if.slave   apu,
  output logic                     busy_o
);

  localparam int NF = APU_NUSFLAGS_CPU;

  logic [31:0] op_a, op_b;
  logic [7:0]  op_key;
  logic        is_scan, fire, pipe_empty;
  logic        unused_in;

  assign op_a   = apu.operands[0];
  assign op_b   = apu.operands[1];
  assign op_key = apu.operands[2][7:0];
  assign unused_in = ^{apu.flags_ds, apu.operands[2][31:8]};

  assign is_scan = (apu.op == APU_WOP_CPU'(STR_OP_SCAN));

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        res_q [LATENCY];
  logic [31:0]        res_d [LATENCY];
  logic [NF-1:0]      flg_q [LATENCY];
  logic [NF-1:0]      flg_d [LATENCY];

  str_state_e    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   sa_q, sa_d;
  logic [7:0]    key_q, key_d;
  logic [31:0]   sres_q, sres_d;
  logic [NF-1:0] sflg_q, sflg_d;

  logic [31:0]   alu_res;
  logic [NF-1:0] alu_flg;

  assign pipe_empty = ~|vld_q;
  assign apu.gnt = apu.req & (state_q == STR_IDLE) &
                   (~is_scan | pipe_empty);
  assign fire = apu.gnt;

  cv32e40p_apu_str_alu #(
    .WOP      (APU_WOP_CPU),
    .NUSFLAGS (NF)
  ) u_alu (
    .op_i     (apu.op),
    .a_i      (op_a),
    .b_i      (op_b),
    .key_i    (op_key),
    .result_o (alu_res),
    .flags_o  (alu_flg)
  );

  // load stage 0 from the ALU and shift the rest
  always_comb begin
    vld_d    = '0;
    res_d    = res_q;
    flg_d    = flg_q;
    vld_d[0] = fire & ~is_scan;
    res_d[0] = alu_res;
    flg_d[0] = alu_flg;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      res_d[i] = res_q[i-1];
      flg_d[i] = flg_q[i-1];
    end
  end

  // scan FSM next state: one byte compared per cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    key_d   = key_q;
    sres_d  = sres_q;
    sflg_d  = sflg_q;
    unique case (state_q)
      STR_IDLE: begin
        if (fire & is_scan) begin
          state_d = STR_SCAN;
          cnt_d   = '0;
          sa_d    = op_a;
          key_d   = op_b[7:0];
          sflg_d  = '0;
          sflg_d[STR_FLAG_ZERO] = has_zero_byte(op_a);
        end
      end
      STR_SCAN: begin
        if (sa_q[{cnt_q, 3'b000} +: 8] == key_q) begin
          state_d = STR_DONE;
          sres_d  = {30'd0, cnt_q};
        end else if (cnt_q == 2'd3) begin
          state_d = STR_DONE;
          sres_d  = '1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      STR_DONE: state_d = STR_IDLE;
      default:  state_d = STR_IDLE;
    endcase
  end

  // state registers for pipe and FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      state_q <= STR_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      key_q   <= '0;
      sres_q  <= '0;
      sflg_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      key_q   <= key_d;
      sres_q  <= sres_d;
      sflg_q  <= sflg_d;
    end
  end

  logic done;
  assign done = (state_q == STR_DONE);

  assign apu.rvalid   = done | vld_q[LATENCY-1];
  assign apu.result   = done ? sres_q : res_q[LATENCY-1];
  assign apu.flags_us = done ? sflg_q : flg_q[LATENCY-1];
  assign busy_o = (|vld_q) | (state_q != STR_IDLE);

endmodule

// File: tb/tb_cv32e40p_apu_str_unit.sv
// Randomised + directed bench for the APU string unit,
// checked every cycle against a transaction-level model.
module tb_cv32e40p_apu_str_unit;
  import cv32e40p_apu_str_pkg::*;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;

  cv32e40p_apu_str_unit_if #(
    .NARGS(3), .WOP(6), .NDSFLAGS(15), .NUSFLAGS(5)
  ) apu ();

  cv32e40p_apu_str_unit #(
    .LATENCY(L), .APU_NARGS_CPU(3), .APU_WOP_CPU(6),
    .APU_NDSFLAGS_CPU(15), .APU_NUSFLAGS_CPU(5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .apu    (apu),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          scan;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic [4:0]  flg;
  } obs_t;

  exp_t mq[$];
  exp_t keep[$];
  obs_t rv_log[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] byt(logic [31:0] w, int i);
    return w[8*i +: 8];
  endfunction

  // What one granted request must return, and when.
  function automatic exp_t model(logic [5:0] op, logic [31:0] a,
                                 logic [31:0] b, logic [31:0] c,
                                 int t);
    exp_t e;
    int k;
    logic [7:0] x;
    e.scan = 0;
    e.res = '0;
    e.flg = '0;
    e.due = t + L;
    for (int i = 0; i < 4; i++)
      if (byt(a, i) == 8'h00) e.flg[1] = 1'b1;
    case (op)
      6'd0: begin
        k = 4;
        for (int i = 3; i >= 0; i--) if (byt(a, i) == 8'h00) k = i;
        e.res = 32'(k);
      end
      6'd1: for (int i = 0; i < 4; i++)
        e.res[i] = (byt(a, i) == byt(b, i));
      6'd2: for (int i = 0; i < 4; i++)
        if (byt(a, i) == c[7:0]) e.res = e.res + 1;
      6'd3: for (int i = 0; i < 4; i++)
        e.res[8*(3-i) +: 8] = byt(a, i);
      6'd4: for (int i = 0; i < 4; i++) begin
        x = byt(a, i);
        if (x >= 8'h61 && x <= 8'h7a) x = x - 8'h20;
        e.res[8*i +: 8] = x;
      end
      6'd5: begin
        e.scan = 1;
        k = 4;
        for (int i = 3; i >= 0; i--) if (byt(a, i) == b[7:0]) k = i;
        e.res = (k == 4) ? 32'hFFFF_FFFF : 32'(k);
        e.due = (k == 4) ? t + 5 : t + 2 + k;
      end
      default: e.flg[0] = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  exp_t cur;
  bit   has_exp, any_out, scan_out, exp_gnt;
  obs_t ob;

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      chk("rst_rvalid", 32'(apu.rvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", apu.result, 32'd0);
      chk("rst_flags", 32'(apu.flags_us), 32'd0);
    end else begin
      has_exp = 0;
      any_out = 0;
      scan_out = 0;
      cur = '{0, 0, '0, '0};
      foreach (mq[i]) begin
        if (mq[i].due >= cyc) begin
          any_out = 1;
          if (mq[i].scan) scan_out = 1;
        end
        if (mq[i].due == cyc) begin
          has_exp = 1;
          cur = mq[i];
        end
      end
      exp_gnt = apu.req && !scan_out &&
                (apu.op != 6'd5 || !any_out);
      chk("gnt", 32'(apu.gnt), 32'(exp_gnt));
      chk("busy", 32'(busy), 32'(any_out));
      chk("rvalid", 32'(apu.rvalid), 32'(has_exp));
      if (has_exp && apu.rvalid) begin
        chk("result", apu.result, cur.res);
        chk("flags", 32'(apu.flags_us), 32'(cur.flg));
      end
      if (apu.rvalid) begin
        ob.cyc = cyc;
        ob.res = apu.result;
        ob.flg = apu.flags_us;
        rv_log.push_back(ob);
      end
      keep.delete();
      foreach (mq[i]) if (mq[i].due > cyc) keep.push_back(mq[i]);
      mq = keep;
      if (apu.req && apu.gnt)
        mq.push_back(model(apu.op, apu.operands[0],
                           apu.operands[1], apu.operands[2], cyc));
    end
  end

  task automatic idle(int n);
    apu.req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c,
                      output int t, output int waited);
    apu.req = 1'b1;
    apu.op = op;
    apu.operands[0] = a;
    apu.operands[1] = b;
    apu.operands[2] = c;
    t = -1;
    waited = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (apu.gnt) begin
        t = cyc;
        break;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    if (t < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: no gnt for op %h in 30 cycles", op);
      apu.req = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      apu.req = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    apu.req = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 40);
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: busy still %b after 40 cycles", busy);
    end
  endtask

  task automatic check_rv(int idx, string nm, logic [31:0] r,
                          logic [4:0] f, int t, int lat);
    if (rv_log.size() <= idx) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_missing: got %0d rvalids required more than %0d",
               nm, rv_log.size(), idx);
    end else begin
      chk({nm, "_res"}, rv_log[idx].res, r);
      chk({nm, "_flg"}, 32'(rv_log[idx].flg), 32'(f));
      chk({nm, "_lat"}, 32'(rv_log[idx].cyc - t), 32'(lat));
    end
  endtask

  function automatic logic [7:0] rbyte();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h41;
      2: return 8'h61;
      3: return 8'h7a;
      4: return 8'h33;
      default: return 8'($urandom);
    endcase
  endfunction

  exp_t pm;
  int t0, t1, w;
  logic [5:0] rop;
  logic [31:0] ra, rb, rc;
  int r;

  initial begin : global_timeout
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    apu.req = 1'b0;
    apu.op = '0;
    apu.operands = '0;
    apu.flags_ds = '0;

    pm = model(6'd0, 32'h0041_4243, 0, 0, 0);
    chk("model_strlen", pm.res, 32'd3);
    pm = model(6'd4, 32'h6162_2E7A, 0, 0, 0);
    chk("model_upper", pm.res, 32'h4142_2E5A);
    pm = model(6'd5, 32'h5533_2211, 32'h33, 0, 0);
    chk("model_scan_due", 32'(pm.due), 32'd4);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    rv_log.delete();
    send(6'd0, 32'h0041_4243, 0, 0, t0, w);
    drain();
    check_rv(0, "strlen", 32'd3, 5'b00010, t0, L);

    rv_log.delete();
    send(6'd4, 32'h6162_2E7A, 0, 0, t0, w);
    send(6'd3, 32'h1122_3344, 0, 0, t1, w);
    drain();
    check_rv(0, "b2b_upper", 32'h4142_2E5A, 5'b0, t0, L);
    check_rv(1, "b2b_rev", 32'h4433_2211, 5'b0, t0, L + 1);

    rv_log.delete();
    send(6'd5, 32'h5533_2211, 32'h33, 0, t0, w);
    drain();
    check_rv(0, "scan_hit", 32'd2, 5'b0, t0, 4);

    rv_log.delete();
    send(6'd5, 32'h0102_0304, 32'hFF, 0, t0, w);
    drain();
    check_rv(0, "scan_miss", 32'hFFFF_FFFF, 5'b0, t0, 5);

    rv_log.delete();
    send(6'd2, 32'h4141_4241, 0, 32'h41, t0, w);
    send(6'd5, 32'h1234_5641, 32'h41, 0, t1, w);
    chk("scan_hold_wait", 32'(w), 32'd2);
    drain();
    check_rv(0, "order_count", 32'd3, 5'b0, t0, L);
    check_rv(1, "order_scan", 32'd0, 5'b0, t0, 5);

    rv_log.delete();
    send(6'h3F, 32'h1122_3344, 0, 0, t0, w);
    drain();
    check_rv(0, "illegal", 32'd0, 5'b00001, t0, L);

    rv_log.delete();
    send(6'd5, 32'h0102_0304, 32'hFF, 0, t0, w);
    idle(1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    send(6'd0, 32'h1122_3300, 0, 0, t1, w);
    chk("post_rst_wait", 32'(w), 32'd0);
    drain();
    chk("post_rst_rvalids", 32'(rv_log.size()), 32'd1);
    check_rv(0, "post_rst", 32'd0, 5'b00010, t1, L);

    repeat (300) begin
      r = $urandom_range(0, 13);
      rop = (r < 12) ? 6'(r % 6) : 6'($urandom_range(6, 63));
      ra = {rbyte(), rbyte(), rbyte(), rbyte()};
      rb = ($urandom_range(0, 1) == 1) ? {24'($urandom), byt(ra, $urandom_range(0, 3))}
                                       : {rbyte(), rbyte(), rbyte(), rbyte()};
      rc = {24'($urandom), rbyte()};
      send(rop, ra, rb, rc, t0, w);
      idle($urandom_range(0, 2));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
